// File: rtl/ser_pkg.sv
// Constants shared by the serializer and deserializer.
package ser_pkg;

  localparam int unsigned SER_DATA_W     = 16;
  localparam int unsigned SER_LEN_W      = $clog2(SER_DATA_W) + 1;
  localparam int unsigned SER_FIFO_DEPTH = 4;
  localparam int unsigned DROP_CNT_W     = 8;

endpackage

// File: rtl/deser_fifo.sv
// First-word-fall-through word buffer.
// A write into a full buffer is taken only when a read happens in the same cycle.
module deser_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             rd_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign rd_valid_o = (count_q != '0);

  always_comb begin
    pop        = rd_valid_o & rd_ready_i;
    wr_ready_o = (count_q != CntW'(DEPTH)) | pop;
    push       = wr_valid_i & wr_ready_o;
    wptr_d     = wptr_q + PtrW'(push);
    rptr_d     = rptr_q + PtrW'(pop);
    count_d    = count_q + CntW'(push) - CntW'(pop);
    // Idle head reads as zero so outputs are clean after reset.
    rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel converter with flush of partial words,
// a FWFT output buffer and saturating accounting of words lost to a full buffer.
module deserializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W     = SER_DATA_W,
  parameter int unsigned FIFO_DEPTH = SER_FIFO_DEPTH,
  localparam int unsigned LEN_W     = $clog2(DATA_W) + 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  data_i,
  input  logic                  data_val_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     deser_data_o,
  output logic [LEN_W-1:0]      deser_len_o,
  output logic                  deser_data_val_o,
  input  logic                  deser_data_ready_i,
  output logic                  drop_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [DATA_W-1:0]       shift_q, shift_d, word;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]        fill;
  logic                    complete, push_valid, push_ready, drop;
  logic                    drop_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [LEN_W+DATA_W-1:0] head;

  always_comb begin
    // Bits are placed directly at their final position, keeping partial words left-aligned.
    word = shift_q;
    if (data_val_i) begin
      word[CntW'(DATA_W - 1) - cnt_q] = data_i;
    end
    fill       = LEN_W'(cnt_q) + LEN_W'(data_val_i);
    complete   = (fill == LEN_W'(DATA_W));
    push_valid = complete | (flush_i & (fill != '0));
    drop       = push_valid & ~push_ready;

    if (push_valid) begin
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      shift_d = word;
      cnt_d   = cnt_q + CntW'(data_val_i);
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  deser_fifo #(
    .WIDTH (LEN_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .wr_valid_i (push_valid),
    .wr_data_i  ({fill, word}),
    .wr_ready_o (push_ready),
    .rd_valid_o (deser_data_val_o),
    .rd_data_o  (head),
    .rd_ready_i (deser_data_ready_i)
  );

  assign deser_len_o  = head[LEN_W+DATA_W-1:DATA_W];
  assign deser_data_o = head[DATA_W-1:0];
  assign drop_o       = drop_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: queue-based word model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_deserializer;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEN_W      = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              srst, din, din_val, flush, ready;
  logic [DATA_W-1:0] dut_data;
  logic [LEN_W-1:0]  dut_len;
  logic              dut_val, dut_drop;
  logic [7:0]        dut_drop_cnt;

  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk_en   = 1'b0;

  logic  pend_m [$];
  word_t fifo_m [$];
  int    drop_cnt_m;
  logic  drop_m;

  deserializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i              (clk),
    .srst_i             (srst),
    .data_i             (din),
    .data_val_i         (din_val),
    .flush_i            (flush),
    .deser_data_o       (dut_data),
    .deser_len_o        (dut_len),
    .deser_data_val_o   (dut_val),
    .deser_data_ready_i (ready),
    .drop_o             (dut_drop),
    .drop_cnt_o         (dut_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: collect accepted bits, form words, then apply the pop and the push.
  always @(posedge clk) begin
    logic [DATA_W-1:0] wd;
    bit have;
    if (srst) begin
      pend_m.delete();
      fifo_m.delete();
      drop_cnt_m = 0;
      drop_m     = 1'b0;
    end else begin
      have   = 1'b0;
      drop_m = 1'b0;
      wd     = '0;
      if (din_val) pend_m.push_back(din);
      if (pend_m.size() == DATA_W || (flush && pend_m.size() > 0)) begin
        for (int i = 0; i < pend_m.size(); i++) wd[DATA_W-1-i] = pend_m[i];
        fifo_word: begin
          word_t w;
          w.data = wd;
          w.len  = LEN_W'(pend_m.size());
          pend_m.delete();
          have = 1'b1;
          if (ready && fifo_m.size() > 0) void'(fifo_m.pop_front());
          if (fifo_m.size() < FIFO_DEPTH) begin
            fifo_m.push_back(w);
          end else begin
            drop_m = 1'b1;
            if (drop_cnt_m < 255) drop_cnt_m++;
          end
        end
      end
      if (!have && ready && fifo_m.size() > 0) void'(fifo_m.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("val", 32'(dut_val), 32'(fifo_m.size() != 0));
      if (fifo_m.size() != 0) begin
        check("data", 32'(dut_data), 32'(fifo_m[0].data));
        check("len", 32'(dut_len), 32'(fifo_m[0].len));
      end
      check("drop", 32'(dut_drop), 32'(drop_m));
      check("drop_cnt", 32'(dut_drop_cnt), 32'(drop_cnt_m));
    end
  end

  task automatic send_bit(input logic b, input logic f);
    din     = b;
    din_val = 1'b1;
    flush   = f;
    @(negedge clk);
    din     = 1'b0;
    din_val = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_a [4];
  logic [DATA_W-1:0] exp_b [5];
  logic [DATA_W-1:0] pat;

  initial begin
    srst = 1'b1; din = 1'b0; din_val = 1'b0; flush = 1'b0; ready = 1'b1;
    exp_a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_b = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_val", 32'(dut_val), 32'h0);
    check("rst_data", 32'(dut_data), 32'h0);
    check("rst_len", 32'(dut_len), 32'h0);
    check("rst_drop", 32'(dut_drop), 32'h0);
    check("rst_drop_cnt", 32'(dut_drop_cnt), 32'h0);
    srst = 1'b0;

    // Back-to-back full word.
    pat = 16'hA5C3;
    for (int i = DATA_W - 1; i >= 1; i--) send_bit(pat[i], 1'b0);
    check("a5c3_early_val", 32'(dut_val), 32'h0);
    send_bit(pat[0], 1'b0);
    check("a5c3_val", 32'(dut_val), 32'h1);
    check("a5c3_data", 32'(dut_data), 32'hA5C3);
    check("a5c3_len", 32'(dut_len), 32'd16);
    @(negedge clk);
    check("a5c3_popped", 32'(dut_val), 32'h0);

    // Partial word flush, then an empty flush.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    do_flush();
    check("flush_val", 32'(dut_val), 32'h1);
    check("flush_data", 32'(dut_data), 32'hB000);
    check("flush_len", 32'(dut_len), 32'd5);
    @(negedge clk);
    do_flush();
    check("empty_flush_val", 32'(dut_val), 32'h0);

    // Flush together with a non-completing bit includes that bit.
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("flush_bit_data", 32'(dut_data), 32'hE000);
    check("flush_bit_len", 32'(dut_len), 32'd4);
    @(negedge clk);

    // Flush together with the completing bit yields only the full word.
    pat = 16'h8001;
    for (int i = DATA_W - 1; i >= 1; i--) send_bit(pat[i], 1'b0);
    send_bit(pat[0], 1'b1);
    check("flush_full_data", 32'(dut_data), 32'h8001);
    check("flush_full_len", 32'(dut_len), 32'd16);
    @(negedge clk);
    check("flush_full_single", 32'(dut_val), 32'h0);

    // Gapped input.
    pat = 16'h1234;
    for (int i = DATA_W - 1; i >= 1; i--) begin
      send_bit(pat[i], 1'b0);
      @(negedge clk);
    end
    check("gap_early_val", 32'(dut_val), 32'h0);
    send_bit(pat[0], 1'b0);
    check("gap_data", 32'(dut_data), 32'h1234);
    check("gap_len", 32'(dut_len), 32'd16);
    @(negedge clk);

    // Back-pressure: five words into a four-entry buffer.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(exp_a[k]);
    send_word(16'h5555);
    check("bp_drop", 32'(dut_drop), 32'h1);
    check("bp_drop_cnt", 32'(dut_drop_cnt), 32'd1);
    check("bp_head_hold", 32'(dut_data), 32'h1111);
    @(negedge clk);
    check("bp_drop_pulse", 32'(dut_drop), 32'h0);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain", 32'(dut_data), 32'(exp_a[k]));
      @(negedge clk);
    end
    check("bp_empty", 32'(dut_val), 32'h0);

    // Full buffer: pop and completing bit in the same cycle.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(exp_b[k]);
    pat = exp_b[4];
    for (int i = DATA_W - 1; i >= 1; i--) send_bit(pat[i], 1'b0);
    ready = 1'b1;
    send_bit(pat[0], 1'b0);
    ready = 1'b0;
    check("full_pop_drop", 32'(dut_drop), 32'h0);
    check("full_pop_drop_cnt", 32'(dut_drop_cnt), 32'd1);
    check("full_pop_head", 32'(dut_data), 32'hC002);
    check("model_occupancy", 32'(fifo_m.size()), 32'd4);
    ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check("full_pop_drain", 32'(dut_data), 32'(exp_b[k]));
      @(negedge clk);
    end
    check("full_pop_empty", 32'(dut_val), 32'h0);

    // Reset mid-word with inputs asserted, then a fresh word right after.
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    srst = 1'b1; din = 1'b1; din_val = 1'b1; flush = 1'b1;
    @(negedge clk);
    srst = 1'b0; din = 1'b0; din_val = 1'b0; flush = 1'b0;
    check("srst_val", 32'(dut_val), 32'h0);
    check("srst_drop_cnt", 32'(dut_drop_cnt), 32'h0);
    for (int i = 0; i < DATA_W - 1; i++) send_bit(1'b1, 1'b0);
    check("srst_no_early", 32'(dut_val), 32'h0);
    send_bit(1'b1, 1'b0);
    check("srst_word_val", 32'(dut_val), 32'h1);
    check("srst_word_data", 32'(dut_data), 32'hFFFF);
    check("srst_word_len", 32'(dut_len), 32'd16);
    check("srst_word_drop_cnt", 32'(dut_drop_cnt), 32'h0);
    @(negedge clk);
    check("srst_single", 32'(dut_val), 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
